// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the 256x8 memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if;
  logic       ReqA;
  logic       WeA;
  logic [7:0] AddrA;
  logic [7:0] WdataA;
  logic       GntA;
  logic       AckA;
  logic [7:0] RdataA;

  logic       ReqB;
  logic       WeB;
  logic [7:0] AddrB;
  logic [7:0] WdataB;
  logic       GntB;
  logic       AckB;
  logic [7:0] RdataB;
  logic       ErrB;

  logic       MemWriteEn;
  logic [7:0] MemAddr;
  logic [7:0] MemDataIn;
  logic [7:0] MemDataOut;

  modport slave (
    input  ReqA, WeA, AddrA, WdataA, ReqB, WeB, AddrB, WdataB, MemDataOut,
    output GntA, AckA, RdataA, GntB, AckB, RdataB, ErrB, MemWriteEn, MemAddr, MemDataIn
  );

  modport master (
    output ReqA, WeA, AddrA, WdataA, ReqB, WeB, AddrB, WdataB, MemDataOut,
    input  GntA, AckA, RdataA, GntB, AckB, RdataB, ErrB, MemWriteEn, MemAddr, MemDataIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-limited arbiter for the single-port 256x8 data memory (port A: CPU, port B: host).
// Optional macro DMEM_ARB_PROTECT_EN blocks port B writes to addresses 0..PROT_TOP.
module dmem_arbiter #(
  parameter int         MAX_BURST = 4,
  parameter logic [7:0] PROT_TOP  = 8'd17
) (
  input  logic           Clk,
  input  logic           Reset,
  dmem_arbiter_if.slave  bus
);

`ifdef DMEM_ARB_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_burst;
  logic [3:0] w_burst_next;
  logic       r_last_b;
  logic       w_last_b_next;
  logic       w_acc_a;
  logic       w_acc_b;
  logic       w_limit;
  logic       w_blocked;

  // State, burst count and last-owner registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_burst  <= 4'd0;
      r_last_b <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_burst  <= w_burst_next;
      r_last_b <= w_last_b_next;
    end
  end

  // Next-state: round-robin tie break in IDLE, release or burst-limit handoff when owned
  always_comb begin
    w_next  = r_state;
    w_acc_a = 1'b0;
    w_acc_b = 1'b0;
    w_limit = (r_burst == BURST_LAST);
    case (r_state)
      IDLE: begin
        if (bus.ReqA && bus.ReqB) begin
          w_next = r_last_b ? OWN_A : OWN_B;
        end else if (bus.ReqA) begin
          w_next = OWN_A;
        end else if (bus.ReqB) begin
          w_next = OWN_B;
        end else begin
          w_next = IDLE;
        end
      end
      OWN_A: begin
        if (bus.ReqA) begin
          w_acc_a = 1'b1;
          w_next  = (w_limit && bus.ReqB) ? OWN_B : OWN_A;
        end else begin
          w_next  = bus.ReqB ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        if (bus.ReqB) begin
          w_acc_b = 1'b1;
          w_next  = (w_limit && bus.ReqA) ? OWN_A : OWN_B;
        end else begin
          w_next  = bus.ReqA ? OWN_A : IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if (w_next != r_state) begin
      w_burst_next = 4'd0;
    end else if ((w_acc_a || w_acc_b) && (r_burst != 4'd15)) begin
      w_burst_next = r_burst + 4'd1;
    end else begin
      w_burst_next = r_burst;
    end

    if ((r_state == OWN_A) && (w_next != OWN_A)) begin
      w_last_b_next = 1'b0;
    end else if ((r_state == OWN_B) && (w_next != OWN_B)) begin
      w_last_b_next = 1'b1;
    end else begin
      w_last_b_next = r_last_b;
    end
  end

  assign w_blocked = PROT_EN & w_acc_b & bus.WeB & (bus.AddrB <= PROT_TOP);

  // Memory-side mux and requester returns; everything is 0 unless an access is in progress
  always_comb begin
    bus.GntA       = (r_state == OWN_A);
    bus.GntB       = (r_state == OWN_B);
    bus.AckA       = w_acc_a;
    bus.AckB       = w_acc_b;
    bus.ErrB       = w_blocked;
    bus.RdataA     = 8'd0;
    bus.RdataB     = 8'd0;
    bus.MemWriteEn = 1'b0;
    bus.MemAddr    = 8'd0;
    bus.MemDataIn  = 8'd0;
    if (w_acc_a) begin
      bus.MemWriteEn = bus.WeA;
      bus.MemAddr    = bus.AddrA;
      bus.MemDataIn  = bus.WdataA;
      bus.RdataA     = bus.MemDataOut;
    end else if (w_acc_b) begin
      bus.MemWriteEn = bus.WeB & ~w_blocked;
      bus.MemAddr    = bus.AddrB;
      bus.MemDataIn  = bus.WdataB;
      bus.RdataB     = bus.MemDataOut;
    end else begin
      bus.MemWriteEn = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of ownership, acks and memory contents.
module tb_dmem_arbiter;
  localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic tb_clear = 1'b1;
  logic [7:0] mem [256];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .PROT_TOP(8'd17)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Behavioural memory: combinational read, write on rising edge
  always @(posedge Clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (bus.MemWriteEn) begin
      mem[bus.MemAddr] <= bus.MemDataIn;
    end
  end
  assign bus.MemDataOut = mem[bus.MemAddr];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none, 1=A, 2=B
  logic [7:0] ref_mem [256];
  int own, run, last, n_own;
  bit e_acc_a, e_acc_b, e_blk, e_we;
  logic [7:0] e_addr, e_din;

  task automatic model_reset();
    own = 0; run = 0; last = 2; e_acc_a = 0; e_acc_b = 0; e_we = 0;
  endtask

  // Compare all outputs against the model a moment after inputs settle, and plan the next owner
  task automatic eval();
    bit mine, other;
    #1;
    e_acc_a = (own == 1) && bus.ReqA;
    e_acc_b = (own == 2) && bus.ReqB;
    e_blk   = PROT_EN && e_acc_b && bus.WeB && (bus.AddrB <= 8'd17);
    e_we    = (e_acc_a && bus.WeA) || (e_acc_b && bus.WeB && !e_blk);
    e_addr  = e_acc_a ? bus.AddrA : (e_acc_b ? bus.AddrB : 8'd0);
    e_din   = e_acc_a ? bus.WdataA : (e_acc_b ? bus.WdataB : 8'd0);
    chk("gnt_a", bus.GntA, own == 1);
    chk("gnt_b", bus.GntB, own == 2);
    chk("ack_a", bus.AckA, e_acc_a);
    chk("ack_b", bus.AckB, e_acc_b);
    chk("err_b", bus.ErrB, e_blk);
    chk("mem_we", bus.MemWriteEn, e_we);
    if (e_acc_a || e_acc_b || own == 0) begin
      chk("mem_addr", bus.MemAddr, e_addr);
      chk("mem_din", bus.MemDataIn, e_din);
    end
    if (e_acc_a && !bus.WeA) chk("rdata_a", bus.RdataA, ref_mem[bus.AddrA]);
    if (e_acc_b && !bus.WeB) chk("rdata_b", bus.RdataB, ref_mem[bus.AddrB]);
    if (own != 1) chk("rdata_a_idle", bus.RdataA, 8'd0);
    if (own != 2) chk("rdata_b_idle", bus.RdataB, 8'd0);
    if (own == 0) begin
      if (bus.ReqA && bus.ReqB) n_own = (last == 1) ? 2 : 1;
      else if (bus.ReqA) n_own = 1;
      else if (bus.ReqB) n_own = 2;
      else n_own = 0;
    end else begin
      mine  = (own == 1) ? bus.ReqA : bus.ReqB;
      other = (own == 1) ? bus.ReqB : bus.ReqA;
      if (!mine) n_own = other ? 3 - own : 0;
      else if (other && run == MAX_BURST - 1) n_own = 3 - own;
      else n_own = own;
    end
  endtask

  task automatic advance();
    @(posedge Clk);
    if (e_we) ref_mem[e_addr] = e_din;
    if (n_own != own) begin
      if (own != 0) last = own;
      run = 0;
    end else if (e_acc_a || e_acc_b) begin
      run = (run < 15) ? run + 1 : 15;
    end
    own = n_own;
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    bus.ReqA = 1'b0; bus.WeA = 1'b0; bus.AddrA = 8'd0; bus.WdataA = 8'd0;
    bus.ReqB = 1'b0; bus.WeB = 1'b0; bus.AddrB = 8'd0; bus.WdataB = 8'd0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle_inputs();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_random();
    if (!(bus.ReqA && !e_acc_a)) begin
      bus.ReqA   = ($urandom_range(0, 3) != 0);
      bus.WeA    = $urandom_range(0, 1) != 0;
      bus.AddrA  = 8'($urandom_range(0, 31));
      bus.WdataA = 8'($urandom);
    end
    if (!(bus.ReqB && !e_acc_b)) begin
      bus.ReqB   = ($urandom_range(0, 3) != 0);
      bus.WeB    = $urandom_range(0, 1) != 0;
      bus.AddrB  = 8'($urandom_range(0, 31));
      bus.WdataB = 8'($urandom);
    end
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    model_reset();
    idle_inputs();
    @(negedge Clk);
    @(negedge Clk);
    tb_clear = 1'b0;
    do_reset();

    // Reset state, then A writes 8'h5A to 8'h20
    eval();
    chk("rst_gnt_a", bus.GntA, 1'b0);
    chk("rst_mem_we", bus.MemWriteEn, 1'b0);
    bus.ReqA = 1'b1; bus.WeA = 1'b1; bus.AddrA = 8'h20; bus.WdataA = 8'h5A;
    eval(); advance();
    eval();
    chk("wr_gnt_a", bus.GntA, 1'b1);
    chk("wr_ack_a", bus.AckA, 1'b1);
    chk("wr_mem_we", bus.MemWriteEn, 1'b1);
    chk("wr_mem_addr", bus.MemAddr, 8'h20);
    advance();
    bus.ReqA = 1'b0;
    eval(); advance();
    bus.ReqA = 1'b1; bus.WeA = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      eval();
      if (bus.AckA) begin
        got = 1'b1;
        chk("rd_rdata_a", bus.RdataA, 8'h5A);
      end
      advance();
    end
    chk("rd_acked", got, 1'b1);

    // Both held: A x4, B x4, A x4 with zero-cycle handoffs
    do_reset();
    bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 8'h20;
    bus.ReqB = 1'b1; bus.WeB = 1'b0; bus.AddrB = 8'h21;
    for (int c = 0; c <= 12; c++) begin
      eval();
      if (c > 0) begin
        chk("burst_ack_a", bus.AckA, ((c - 1) / 4) % 2 == 0);
        chk("burst_ack_b", bus.AckB, ((c - 1) / 4) % 2 == 1);
      end
      advance();
    end

    // B releases with A idle: dead IDLE cycle, then A granted after its request
    do_reset();
    bus.ReqB = 1'b1; bus.WeB = 1'b0; bus.AddrB = 8'h03;
    eval(); advance();
    eval(); advance();
    bus.ReqB = 1'b0;
    eval(); advance();
    eval();
    chk("drop_gnt_b", bus.GntB, 1'b0);
    chk("drop_mem_we", bus.MemWriteEn, 1'b0);
    chk("drop_mem_addr", bus.MemAddr, 8'd0);
    advance();
    bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 8'h04;
    eval(); advance();
    eval();
    chk("drop_gnt_a", bus.GntA, 1'b1);
    advance();

    // Reset mid write burst: outputs fall asynchronously and the write is dropped
    do_reset();
    bus.ReqA = 1'b1; bus.WeA = 1'b1; bus.AddrA = 8'h40; bus.WdataA = 8'hC3;
    eval(); advance();
    eval();
    #2 Reset = 1'b1;
    #1;
    chk("arst_gnt_a", bus.GntA, 1'b0);
    chk("arst_ack_a", bus.AckA, 1'b0);
    chk("arst_mem_we", bus.MemWriteEn, 1'b0);
    model_reset();
    idle_inputs();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      eval(); advance();
    end
    bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 8'h40;
    for (int c = 0; c < 3; c++) begin
      eval(); advance();
    end
    chk("arst_mem_kept", mem[8'h40], 8'h00);

    // Protected region: preload 8'h07 via A, then B writes 8'h07 and 8'h12
    do_reset();
    bus.ReqA = 1'b1; bus.WeA = 1'b1; bus.AddrA = 8'h07; bus.WdataA = 8'h3C;
    eval(); advance();
    eval(); advance();
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b1; bus.WeB = 1'b1; bus.AddrB = 8'h07; bus.WdataB = 8'hEE;
    eval(); advance();
    eval();
    chk("prot_ack_b", bus.AckB, 1'b1);
    chk("prot_err_b", bus.ErrB, PROT_EN);
    chk("prot_mem_we", bus.MemWriteEn, !PROT_EN);
    advance();
    bus.AddrB = 8'h12; bus.WdataB = 8'h77;
    eval();
    chk("prot12_mem_we", bus.MemWriteEn, 1'b1);
    chk("prot12_err_b", bus.ErrB, 1'b0);
    advance();
    bus.ReqB = 1'b0;
    bus.ReqA = 1'b1; bus.WeA = 1'b0; bus.AddrA = 8'h07;
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      eval();
      if (bus.AckA) begin
        got = 1'b1;
        chk("prot_rdata_a", bus.RdataA, PROT_EN ? 8'h3C : 8'hEE);
      end
      advance();
    end
    chk("prot_rd_acked", got, 1'b1);

    // Randomized traffic against the model
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      eval();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port 256x8 data memory (combinational read, write on posedge Clk).
- Port A is the processor load/store path; port B is the host/loader path used for preload, inspection and debug.
- Grants are round-robin with a burst limit, and the arbiter drives the memory's WriteEn/DataAddress/DataIn.
- It returns read data and per-access acknowledges to the owning requester.

Parameters:
- MAX_BURST, 4, maximum consecutive accesses by one owner while the other requester is waiting (1..15).
- PROT_TOP, 8'd17, highest write-protected address; used only with the optional feature.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- ReqA  in  1  port A access request, level
- WeA  in  1  port A write (1) / read (0)
- AddrA  in  8  port A address
- WdataA  in  8  port A write data
- GntA  out  1  port A owns memory (registered)
- AckA  out  1  port A access performed this cycle
- RdataA  out  8  port A read data (valid when AckA & ~WeA)
- ReqB, WeB, AddrB, WdataB, GntB, AckB, RdataB: same as A, for port B
- ErrB  out  1  port B write blocked (optional feature; tied 0 otherwise)
- MemWriteEn  out  1  to memory WriteEn
- MemAddr  out  8  to memory DataAddress
- MemDataIn  out  8  to memory DataIn
- MemDataOut  in  8  from memory DataOut

Behaviour:
- Clocking: one clock; reset asynchronous, active-high. Reset forces IDLE, GntA=GntB=0, burst count 0, last-owner=B (so A wins the first tie), ErrB=0.
- Reset mid-access: MemWriteEn falls immediately (combinational from grant registers); an in-flight write is dropped.
- States: IDLE, OWN_A, OWN_B. GntA = (state==OWN_A), GntB = (state==OWN_B).
- IDLE:
  - ReqA only -> OWN_A; ReqB only -> OWN_B.
  - Both requesting -> the port that is not last-owner.
  - Neither -> stay IDLE.
  - Grant latency is 1 cycle from Req; no memory access occurs in IDLE.
- OWN_X access cycle (ReqX high):
  - MemAddr=AddrX, MemWriteEn=WeX, MemDataIn=WdataX, AckX=1.
  - RdataX=MemDataOut in the same cycle.
  - Burst count increments, saturating at 15.
- OWN_X, ReqX low: no access, AckX=0, next state = other port if it is requesting, else IDLE.
- Burst limit: in OWN_X with ReqX high, burst count == MAX_BURST-1 and the other Req high -> this access completes, next state = other port.
  - Burst count clears on every state change.
  - last-owner updates to X on leaving OWN_X.
- Handoff on ReqX drop costs 1 dead cycle; burst-limit handoff costs 0 dead cycles.
- No grant: MemWriteEn=0, MemAddr=0, MemDataIn=0. Rdata of the non-owning port is 0.
- Ack of the non-owning port is always 0.
- Requesters must hold We/Addr/Wdata stable while Req is high and not yet acked.
- Simultaneous Req rise on both ports in IDLE: round-robin as above; the loser waits for release or the burst limit.

Optional Feature:
- Macro: DMEM_ARB_PROTECT_EN.
- Defined:
  - A port B write with AddrB <= PROT_TOP is suppressed (MemWriteEn=0).
  - AckB still 1 so the requester advances; ErrB pulses high for that cycle.
  - Port A is never blocked; port B reads are never blocked.
- Not defined: ErrB tied 0; all port B writes pass through.

Test Plan:
- Reset, then ReqA=1 WeA=1 AddrA=8'h20 WdataA=8'h5A -> GntA=1 on cycle 1, AckA=1, MemWriteEn=1, MemAddr=8'h20; later A read of 8'h20 -> RdataA=8'h5A in the ack cycle.
- ReqA and ReqB both held high from IDLE with MAX_BURST=4 -> grants alternate A(4 acks), B(4 acks), A(4 acks), with no dead cycle between owners.
- OWN_B, ReqB drops while ReqA=0 -> IDLE next cycle, MemWriteEn=0, MemAddr=0; ReqA then rises -> GntA the following cycle.
- Reset asserted mid write burst of A -> GntA, AckA and MemWriteEn drop without waiting for a clock edge; after release with no requests, state stays IDLE.
- With DMEM_ARB_PROTECT_EN: B write to 8'h07 -> MemWriteEn=0, AckB=1, ErrB=1, and A reads 8'h07 unchanged. B write to 8'h12 -> MemWriteEn=1, ErrB=0.
- Without DMEM_ARB_PROTECT_EN: the same B write to 8'h07 is performed and ErrB stays 0.
